ret_stack: RTL and testbench
============================

Name: ret_stack

Overview:
- Hardware return-address stack that drives the PC's jump-target (`in`) and `load` inputs.
- Call sequencer pushes the return address (PC+1) on a call; a return pops the address and presents it as a one-cycle load request to the PC.
- Sits beside the PC and is the producer side of the PC's load interface.
- Pure storage and handshake logic. No address arithmetic inside.

Parameters:
- WIDTH, 16, bit width of stored addresses and of `target`.
- DEPTH, 8, number of entries. Must be ≥2; need not be a power of 2.
- CW, $clog2(DEPTH+1), width of `count`. Derived, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- push  input  1  request to store `push_addr` on top of stack.
- push_addr  input  WIDTH  return address to store.
- pop  input  1  request to remove top entry and issue it to the PC.
- target  output  WIDTH  registered jump address; wires to PC `in`.
- load  output  1  registered one-cycle strobe; wires to PC `load`.
- count  output  CW  current number of valid entries, 0..DEPTH.
- empty  output  1  count==0, combinational from count.
- full  output  1  count==DEPTH, combinational from count.
- overflow  output  1  sticky: a push was dropped.
- underflow  output  1  sticky: a pop hit an empty stack.

Behaviour:
- Reset (synchronous, sampled on rising clk, overrides all requests):
  - count=0, target=0, load=0, overflow=0, underflow=0.
  - Memory contents are don't-care.
  - Reset asserted mid-sequence discards all entries. A load pulse scheduled by a pop in the reset cycle is suppressed.
- All state updates on rising clk. `target` and `load` change one cycle after the pop is sampled (latency 1).
- `load` is high for exactly the cycle after an accepted pop. Back-to-back pops give consecutive load cycles with successive targets.
- `target` holds its last value when load=0.
- Push only, not full: mem[count] <= push_addr; count <= count+1; load <= 0.
- Push only, full: stack unchanged; overflow <= 1; load <= 0.
- Pop only, not empty: target <= mem[count-1]; load <= 1; count <= count-1.
- Pop only, empty: target unchanged; load <= 0; underflow <= 1.
- Push and pop same cycle, not empty (tail-call / replace top):
  - target <= mem[count-1]; mem[count-1] <= push_addr; load <= 1; count unchanged.
  - Legal when full. No overflow.
- Push and pop same cycle, empty (bypass):
  - target <= push_addr; load <= 1; count stays 0; no underflow.
- Neither request: load <= 0; everything else holds.
- overflow and underflow remain set until reset. No other clear path.
- Address values are stored bit-exact, with no sign or width interpretation.
- Reads use the pre-update top. Writes use the post-decision index.
- No combinational path from any input to `target` or `load`.

Test Plan:
- Reset, then push 100, push 200; pop; pop:
  - Pops give target=200 with load=1 for one cycle, then target=100 with load=1.
  - count ends 0 and empty=1.
- Pop on empty after reset:
  - load stays 0, target=0, underflow=1.
  - A subsequent push 7 then pop returns 7, and underflow is still 1.
- Push 1..8 (DEPTH=8), then push 9:
  - full=1 after the 8th push; 9th push dropped and overflow=1.
  - Eight pops return 8,7,…,1 on consecutive load cycles.
- Push 0x8285 (-32123), push 12345, then push 22222 with pop in the same cycle:
  - Same-cycle push/pop gives target=12345, load=1, count=2.
  - Next pop returns 22222, then 0x8285.
- Push and pop same cycle on empty with push_addr=22222:
  - target=22222, load=1, count=0, underflow=0.
- Push 5, push 6, then assert reset together with pop:
  - Next cycle load=0, target=0, count=0, flags 0.
  - A following pop sets underflow.

Source files
------------

// File: rtl/ret_stack.sv
`default_nettype none
// ============================================================================
// Module   : ret_stack
// Purpose  : Hardware return-address stack feeding a program counter's
//            jump-target / load interface. A call pushes its return address;
//            a return pops the top entry and presents it as a registered,
//            one-cycle load request. Pure storage and handshake logic.
//
// Ports    : clk        in   1      rising-edge clock
//            reset      in   1      synchronous, active-high reset
//            push       in   1      store push_addr on top of stack
//            push_addr  in   WIDTH  return address to store
//            pop        in   1      remove top entry and issue it to the PC
//            target     out  WIDTH  registered jump address (PC 'in')
//            load       out  1      registered one-cycle strobe (PC 'load')
//            count      out  CW     valid entries, 0..DEPTH
//            empty      out  1      count == 0
//            full       out  1      count == DEPTH
//            overflow   out  1      sticky: a push was dropped
//            underflow  out  1      sticky: a pop hit an empty stack
//
// Revision : 1.0  initial release
// ============================================================================
module ret_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_addr,
    input  logic             pop,
    output logic [WIDTH-1:0] target,
    output logic             load,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    // Index width for the storage array; DEPTH need not be a power of two.
    localparam int c_IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_target;
    logic             r_load;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_empty;
    logic             w_full;
    logic [c_IW-1:0]  w_top_idx;
    logic [c_IW-1:0]  w_push_idx;
    logic             w_mem_we;
    logic [c_IW-1:0]  w_mem_widx;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

    // Top-of-stack index (pre-update) and next free slot. w_top_idx is only
    // used when not empty; w_push_idx only when not full, so truncation is
    // safe in both cases.
    assign w_top_idx  = c_IW'(r_count - CW'(1));
    assign w_push_idx = c_IW'(r_count);

    // Memory write decision: a plain push writes the next free slot; a
    // same-cycle push/pop on a non-empty stack replaces the top entry.
    // A push/pop on an empty stack bypasses storage entirely.
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_widx = w_push_idx;
        if (!reset && push) begin
            if (pop) begin
                if (!w_empty) begin
                    w_mem_we   = 1'b1;
                    w_mem_widx = w_top_idx;
                end
            end else if (!w_full) begin
                w_mem_we   = 1'b1;
                w_mem_widx = w_push_idx;
            end
        end
    end

    // Storage has no reset: contents are meaningless until pushed.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_widx] <= push_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_target    <= '0;
            r_load      <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_load <= 1'b0;
            if (push && pop) begin
                // Tail-call: issue the old top, count unchanged, legal when full.
                r_load <= 1'b1;
                if (w_empty) begin
                    r_target <= push_addr;
                end else begin
                    r_target <= r_mem[w_top_idx];
                end
            end else if (push) begin
                if (w_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_count <= r_count + CW'(1);
                end
            end else if (pop) begin
                if (w_empty) begin
                    r_underflow <= 1'b1;
                end else begin
                    r_target <= r_mem[w_top_idx];
                    r_load   <= 1'b1;
                    r_count  <= r_count - CW'(1);
                end
            end
        end
    end

    assign target    = r_target;
    assign load      = r_load;
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_ret_stack.sv
`default_nettype none
// ============================================================================
// Module   : tb_ret_stack
// Purpose  : Directed self-checking bench for ret_stack (WIDTH=16, DEPTH=8).
//            Expected pop targets are queued when each stimulus step is
//            driven and compared when the DUT raises load.
//
// Ports    : none
//
// Revision : 1.0  initial release
// ============================================================================
module tb_ret_stack;

    logic        clk;
    logic        reset;
    logic        push;
    logic [15:0] push_addr;
    logic        pop;
    logic [15:0] target;
    logic        load;
    logic [3:0]  count;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        underflow;

    int          n_checks;
    int          n_pass;
    int          n_fail;
    logic [15:0] q_exp [$];
    logic [15:0] tb_last;

    ret_stack #(
        .WIDTH(16),
        .DEPTH(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_addr(push_addr),
        .pop      (pop),
        .target   (target),
        .load     (load),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overflow (overflow),
        .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus. When a load is expected, the target is queued
    // now and popped once the DUT presents it; otherwise target must hold.
    task automatic step(input bit p, input logic [15:0] a, input bit q,
                        input bit r, input bit exp_load, input logic [15:0] exp_t);
        logic [15:0] e;
        @(negedge clk);
        push      = p;
        push_addr = a;
        pop       = q;
        reset     = r;
        if (exp_load) q_exp.push_back(exp_t);
        @(posedge clk);
        #1;
        if (r) tb_last = 16'h0;
        chk("load", {31'b0, load}, {31'b0, exp_load});
        if (load === 1'b1) begin
            if (q_exp.size() == 0) begin
                chk("sb_underrun", 32'd1, 32'd0);
            end else begin
                e = q_exp.pop_front();
                chk("target", {16'b0, target}, {16'b0, e});
                tb_last = e;
            end
        end else begin
            chk("target_hold", {16'b0, target}, {16'b0, tb_last});
        end
    endtask

    task automatic chk_state(input string tag, input int c, input bit em, input bit fu,
                             input bit ov, input bit un);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".empty"}, {31'b0, empty}, {31'b0, em});
        chk({tag, ".full"}, {31'b0, full}, {31'b0, fu});
        chk({tag, ".overflow"}, {31'b0, overflow}, {31'b0, ov});
        chk({tag, ".underflow"}, {31'b0, underflow}, {31'b0, un});
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        n_fail    = 0;
        tb_last   = 16'h0;
        reset     = 1'b1;
        push      = 1'b0;
        pop       = 1'b0;
        push_addr = 16'h0;

        // Reset state
        step(0, 16'd0, 0, 1, 0, 16'd0);
        chk_state("reset", 0, 1, 0, 0, 0);

        // Basic LIFO order
        step(1, 16'd100, 0, 0, 0, 16'd0);
        step(1, 16'd200, 0, 0, 0, 16'd0);
        chk_state("two_pushed", 2, 0, 0, 0, 0);
        step(0, 16'd0, 1, 0, 1, 16'd200);
        step(0, 16'd0, 1, 0, 1, 16'd100);
        chk_state("drained", 0, 1, 0, 0, 0);
        step(0, 16'd0, 0, 0, 0, 16'd0);

        // Pop on empty, then recovery with underflow still sticky
        step(0, 16'd0, 0, 1, 0, 16'd0);
        step(0, 16'd0, 1, 0, 0, 16'd0);
        chk_state("empty_pop", 0, 1, 0, 0, 1);
        step(1, 16'd7, 0, 0, 0, 16'd0);
        step(0, 16'd0, 1, 0, 1, 16'd7);
        chk_state("after_7", 0, 1, 0, 0, 1);

        // Fill, overflow, drain on consecutive load cycles
        step(0, 16'd0, 0, 1, 0, 16'd0);
        for (int i = 1; i <= 8; i++) step(1, 16'(i), 0, 0, 0, 16'd0);
        chk_state("filled", 8, 0, 1, 0, 0);
        step(1, 16'd9, 0, 0, 0, 16'd0);
        chk_state("overflowed", 8, 0, 1, 1, 0);
        for (int i = 8; i >= 1; i--) step(0, 16'd0, 1, 0, 1, 16'(i));
        chk_state("emptied", 0, 1, 0, 1, 0);
        step(0, 16'd0, 0, 0, 0, 16'd0);

        // Tail-call replace-top with bit-exact negative pattern
        step(0, 16'd0, 0, 1, 0, 16'd0);
        step(1, 16'h8285, 0, 0, 0, 16'd0);
        step(1, 16'd12345, 0, 0, 0, 16'd0);
        step(1, 16'd22222, 1, 0, 1, 16'd12345);
        chk_state("tailcall", 2, 0, 0, 0, 0);
        step(0, 16'd0, 1, 0, 1, 16'd22222);
        step(0, 16'd0, 1, 0, 1, 16'h8285);
        chk_state("tail_drained", 0, 1, 0, 0, 0);

        // Push+pop on empty bypasses storage
        step(0, 16'd0, 0, 1, 0, 16'd0);
        step(1, 16'd22222, 1, 0, 1, 16'd22222);
        chk_state("bypass", 0, 1, 0, 0, 0);

        // Reset overrides a pop in the same cycle
        step(0, 16'd0, 0, 1, 0, 16'd0);
        step(1, 16'd5, 0, 0, 0, 16'd0);
        step(1, 16'd6, 0, 0, 0, 16'd0);
        step(0, 16'd0, 1, 1, 0, 16'd0);
        chk_state("reset_pop", 0, 1, 0, 0, 0);
        step(0, 16'd0, 1, 0, 0, 16'd0);
        chk_state("post_reset_pop", 0, 1, 0, 0, 1);

        step(0, 16'd0, 0, 0, 0, 16'd0);
        chk("sb_empty", 32'(q_exp.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
